// File: rtl/crc32c_frame_ctrl.sv
// ----------------------------------------------------------------------------
// crc32c_frame_ctrl
//
// Frame sequencer around a single 32-bit parallel CRC32C step
// (polynomial 0x1EDC6F41, MSB-first Galois form). It takes SOF/EOF-delimited
// 32-bit words and keeps a running CRC. At end of frame it reports the
// finalised CRC, the word count and an error flag on a valid/ready port.
//
// Optional feature macro: CRC32C_CHECK_EN
//   undefined : generate mode. The EOF word is folded into the CRC.
//   defined   : check mode. The EOF word is captured as the received CRC and
//               is not folded into the CRC. m_match reports whether it equals
//               the reported CRC.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   s_valid  in   1      input word valid
//   s_ready  out  1      controller can accept a word (state != DONE)
//   s_data   in   32     input word, bit 0 -> crc32c data_in[0]
//   s_sof    in   1      word is first of frame
//   s_eof    in   1      word is last of frame
//   m_valid  out  1      result valid (state == DONE)
//   m_ready  in   1      result consumed
//   m_crc    out  32     crc_q ^ XOROUT
//   m_len    out  LEN_W  words accepted in frame (saturating)
//   m_err    out  1      restart-by-SOF or length overflow seen in this frame
//   busy     out  1      state == RUN
//   m_match  out  1      (CRC32C_CHECK_EN only) m_crc equals captured EOF word
// ----------------------------------------------------------------------------

// Pure combinational CRC32C step over one 32-bit word with a zero starting
// state. Because a full-width step is linear and symmetric in state and data,
// crc_next(state, data) == crc32c(state ^ data), so the caller pre-XORs.
module crc32c (
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY = 32'h1EDC_6F41;

  logic [31:0] shreg;

  always_comb begin
    shreg = data_in;
    for (int i = 0; i < 32; i++) begin
      if (shreg[31]) begin
        shreg = {shreg[30:0], 1'b0} ^ POLY;
      end else begin
        shreg = {shreg[30:0], 1'b0};
      end
    end
    crc_out = shreg;
  end
endmodule

module crc32c_frame_ctrl #(
  parameter logic [31:0] SEED   = 32'hFFFF_FFFF,
  parameter logic [31:0] XOROUT = 32'hFFFF_FFFF,
  parameter int          LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_sof,
  input  logic             s_eof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_crc,
  output logic [LEN_W-1:0] m_len,
  output logic             m_err,
`ifdef CRC32C_CHECK_EN
  output logic             m_match,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;

  logic             accept;
  logic             start;
  logic             fold;
  logic [31:0]      crc_base;
  logic [31:0]      step_in;
  logic [31:0]      crc_step;

`ifdef CRC32C_CHECK_EN
  logic [31:0]      eof_q, eof_d;
`endif

  // Handshake outputs are pure decodes of the registered state.
  assign s_ready = (state_q != S_DONE);
  assign m_valid = (state_q == S_DONE);
  assign busy    = (state_q == S_RUN);

  assign accept  = s_valid && s_ready;

  // Any SOF word (in IDLE or RUN) opens a fresh frame from SEED.
  assign start    = accept && s_sof;
  assign crc_base = start ? SEED : crc_q;
  assign step_in  = crc_base ^ s_data;

`ifdef CRC32C_CHECK_EN
  // The EOF word carries the received CRC, so it never enters the CRC.
  assign fold = !s_eof;
`else
  assign fold = 1'b1;
`endif

  crc32c u_crc32c (
    .data_in (step_in),
    .crc_out (crc_step)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    err_d   = err_q;
`ifdef CRC32C_CHECK_EN
    eof_d   = eof_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Non-SOF words are dropped here without any side effect.
        if (start) begin
          crc_d   = fold ? crc_step : crc_base;
          len_d   = LEN_W'(1);
          state_d = s_eof ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        if (start) begin
          crc_d   = fold ? crc_step : crc_base;
          len_d   = LEN_W'(1);
          err_d   = 1'b1;
          state_d = s_eof ? S_DONE : S_RUN;
        end else if (accept) begin
          crc_d = fold ? crc_step : crc_base;
          if (len_q == LEN_MAX) begin
            err_d = 1'b1;
          end else begin
            len_d = len_q + LEN_W'(1);
          end
          if (s_eof) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (m_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef CRC32C_CHECK_EN
    if (accept && s_eof && state_q != S_DONE) begin
      eof_d = s_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      crc_q   <= SEED;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

`ifdef CRC32C_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eof_q <= '0;
    end else begin
      eof_q <= eof_d;
    end
  end

  // Gated by DONE so the reset value (m_crc may equal eof_q) reads as 0.
  assign m_match = (state_q == S_DONE) && (m_crc == eof_q);
`endif

  assign m_crc = crc_q ^ XOROUT;
  assign m_len = len_q;
  assign m_err = err_q;

endmodule

// File: doc/crc32c_frame_ctrl.md
# crc32c_frame_ctrl

Frame sequencer for the 32-bit parallel CRC32C step (polynomial 0x1EDC6F41). It accepts a stream of 32-bit words delimited by start-of-frame and end-of-frame markers, and holds the running CRC register around one combinational `crc32c` datapath instance. At end of frame it presents the finalised CRC, the word count and an error flag on a valid/ready result port. It sits between a word-wide packet source and the framing logic that appends or checks the CRC.

## Interface
- `SEED`, default 32'hFFFF_FFFF: initial CRC state at start of frame.
- `XOROUT`, default 32'hFFFF_FFFF: final XOR applied to the reported CRC.
- `LEN_W`, default 16: width of the word counter.

Ports:
- `clk`  in  1: single clock; everything is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `s_valid`  in  1: input word valid.
- `s_ready`  out  1: controller can accept a word.
- `s_data`  in  32: input word; bit 0 maps to `crc32c` `data_in[0]`.
- `s_sof`  in  1: the word is the first of a frame.
- `s_eof`  in  1: the word is the last of a frame.
- `m_valid`  out  1: result valid.
- `m_ready`  in  1: result consumed.
- `m_crc`  out  32: finalised CRC.
- `m_len`  out  LEN_W: number of words accepted in the frame.
- `m_err`  out  1: a protocol error or length overflow occurred in this frame.
- `busy`  out  1: a frame is in progress (state RUN).
- `m_match`  out  1: present only with `CRC32C_CHECK_EN`; see Configuration.

## Operation
- **Step function.** The step is `nxt = crc32c(data_in = crc_q ^ s_data)`. The `crc32c` equations are symmetric in state and data, so one instance with a pre-XOR is sufficient.
- **Accept rule.** A word is accepted when `s_valid && s_ready` at a rising edge.
- **States.** IDLE, RUN, DONE. The state is held in a registered encoding.
- **IDLE** (`s_ready`=1):
  - Accepted word with `s_sof`=1: `crc_q <= step(SEED ^ s_data)` and `len <= 1`. The next state is DONE if `s_eof`=1, otherwise RUN.
  - Accepted word with `s_sof`=0: the word is discarded and the state does not change.
- **RUN** (`s_ready`=1):
  - Accepted word: `crc_q <= step(crc_q ^ s_data)` and `len <= len + 1`. If `s_eof`=1, the next state is DONE.
  - Word with `s_sof`=1 in RUN: the current frame is abandoned. The word restarts a new frame as in IDLE, and `err_pend` is set so the new frame reports `m_err`=1.
  - Length overflow: the counter saturates at all-ones. Any word accepted while the counter is saturated sets `err_pend`.
- **DONE** (`s_ready`=0, `m_valid`=1):
  - Outputs: `m_crc = crc_q ^ XOROUT`, `m_len = len`, `m_err = err_pend`, all held stable until `m_ready`.
  - On `m_ready`: go to IDLE and clear `err_pend`. `crc_q` and `len` are reinitialised on the next SOF.
- **Other outputs.** `busy` = (state == RUN).

## Timing
- **Reset values:**
  - State IDLE, `crc_q`=SEED, `len`=0, `err_pend`=0.
  - `m_valid`=0, `m_crc`=SEED^XOROUT, `m_len`=0, `m_err`=0, `busy`=0, `s_ready`=1, `m_match`=0.
- **Output decode.** `s_ready` and `m_valid` are decoded from registered state only, with no combinational path from `s_valid`, `m_ready` or the data inputs.
- **Latency.** EOF accepted at edge k gives `m_valid`=1 in the cycle after edge k.
- **Throughput.** One word per cycle inside a frame. Each frame costs one bubble (the DONE cycle) when `m_ready`=1, so an N-word frame occupies N+1 cycles.
- **Stall.** With `m_ready`=0, DONE holds indefinitely and `s_ready` stays 0. Input words are not lost; the source must hold them.
- **Reset mid-frame.** Reset asynchronously aborts the frame, with no result emitted.

## Configuration
- **`CRC32C_CHECK_EN` defined.** Check mode is compiled in:
  - The EOF word is treated as the received CRC and is not folded into `crc_q`.
  - `m_crc` is the CRC over the preceding words, XORed with XOROUT.
  - `m_match` = (`m_crc` == registered EOF word).
  - `m_len` still counts the EOF word.
  - For an SOF+EOF single word, `m_crc` = SEED^XOROUT.
- **`CRC32C_CHECK_EN` undefined.**
  - The `m_match` port and the EOF capture register are absent.
  - The EOF word is folded into the CRC like any other word (generate mode).

## Test plan
- **Single-word frame.** SOF+EOF word 32'hFFFF_FFFE, default params → `m_valid` next cycle with `m_crc`=32'hE123_90BE, `m_len`=1, `m_err`=0.
- **Two-word frame.** Words 32'hFFFF_FFFF (SOF) then 32'h0000_0001 (EOF) → `m_crc`=32'hE123_90BE, `m_len`=2, total 3 cycles with `m_ready`=1.
- **Backpressure.**
  - Hold `m_ready`=0 for 5 cycles after EOF → `s_ready`=0 and `m_*` stable throughout.
  - Release `m_ready` → IDLE, and the next SOF word is accepted the following cycle.
- **Protocol errors.**
  - A non-SOF word in IDLE is ignored and produces no result.
  - SOF mid-frame restarts the frame; the restarted frame ends with `m_err`=1 and `m_len` counting from the restart word.
- **Overflow and reset.**
  - `LEN_W`=2, 5-word frame → `m_len`=3, `m_err`=1.
  - `rst` pulse mid-frame → all outputs return to their reset values and no `m_valid` is produced.
- **`CRC32C_CHECK_EN` build.**
  - SOF word 32'hFFFF_FFFE, EOF word 32'hE123_90BE → `m_match`=1, `m_len`=2.
  - The same frame with EOF word 32'h0 → `m_match`=0.
